// File: rtl/ram.sv
// Single-port RAM: the write happens at posedge when st=1.
// The read of address ad is combinational.
module ram #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic [ADDRESS_WIDTH-1:0] ad,
    input  logic                     st,
    input  logic [BUS_WIDTH-1:0]     X,
    output logic [BUS_WIDTH-1:0]     O
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [BUS_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (st) begin
            mem[ad] <= X;
        end
    end

    assign O = mem[ad];

endmodule

// File: rtl/wrap_counter.sv
// Modulo-2^WIDTH up-counter with enable and synchronous reset.
// The FIFO controller uses one for its write pointer and one for its read pointer.
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // The natural overflow of the adder provides the wrap from max back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller built around one single-port RAM.
// Each cycle is either a refill of the registered output slot (read) or a push (write), never both.
module ram_fifo_ctrl #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BUS_WIDTH-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BUS_WIDTH-1:0]     out_data,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic [ADDRESS_WIDTH-1:0] ram_ad,
    output logic                     ram_st,
    output logic [BUS_WIDTH-1:0]     ram_X,
    input  logic [BUS_WIDTH-1:0]     ram_O
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int CW    = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]            mem_count_reg;
    logic                     out_valid_reg;
    logic [BUS_WIDTH-1:0]     out_data_reg;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic                     pop;
    logic                     fill;
    logic                     wr_en;

    // A refill claims the RAM port first; pushes only get the leftover cycles.
    always_comb begin
        pop      = out_valid_reg && out_ready;
        fill     = (mem_count_reg != '0) && (!out_valid_reg || pop);
        in_ready = !rst && !fill && (mem_count_reg != DEPTH_C);
        wr_en    = in_valid && in_ready;
        ram_st   = wr_en;
        ram_ad   = wr_en ? wr_ptr : rd_ptr;
        ram_X    = in_data;
    end

    wrap_counter #(.WIDTH(ADDRESS_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (wr_en),
        .count (wr_ptr)
    );

    wrap_counter #(.WIDTH(ADDRESS_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (fill),
        .count (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_count_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (fill) begin
            out_data_reg  <= ram_O;
            out_valid_reg <= 1'b1;
            mem_count_reg <= mem_count_reg - CW'(1);
        end else begin
            if (wr_en) begin
                mem_count_reg <= mem_count_reg + CW'(1);
            end
            // out_data keeps its last value when the slot empties.
            if (pop) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign level     = mem_count_reg + CW'(out_valid_reg);

endmodule
